// File: rtl/regchk_pkg.sv
// Shared types and constants for the register-file write checker.
package regchk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_e;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd1;
  localparam logic [1:0] FAIL_MISMATCH = 2'd2;
  localparam logic [1:0] FAIL_ABORT    = 2'd3;

  localparam int MODE_UNORDERED = 0;
  localparam int MODE_STRICT    = 1;
endpackage

// File: rtl/regchk_entry_match.sv
// One expectation table entry plus its compare against the snooped regfile write.
module regchk_entry_match #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [XLEN-1:0] cfg_data,
  input  logic [AW-1:0]   rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  output logic            addr_hit,
  output logic            full_hit
);
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] data_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (we) begin
      addr_q <= cfg_addr;
      data_q <= cfg_data;
    end
  end

  assign addr_hit = (rf_waddr == addr_q);
  assign full_hit = addr_hit && (rf_wdata == data_q);
endmodule

// File: rtl/regfile_write_checker.sv
// Snoops the regfile write port and checks writes against a programmed
// expectation table; reports a pass/fail verdict with per-entry match mask.
module regfile_write_checker
  import regchk_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NUM_EXP = 8,
  parameter int TW      = 24,
  localparam int IW     = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int NW     = $clog2(NUM_EXP) + 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               rf_we,
  input  logic [AW-1:0]      rf_waddr,
  input  logic [XLEN-1:0]    rf_wdata,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [XLEN-1:0]    cfg_data,
  input  logic [NW-1:0]      num_exp,
  input  logic [1:0]         mode,
  input  logic [TW-1:0]      timeout_cycles,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [1:0]         fail_code,
  output logic [NUM_EXP-1:0] match_mask,
  output logic [TW-1:0]      cycle_count
);
  state_e             state_q, state_d;
  logic [NW-1:0]      ptr_q, ptr_d, n_q, n_d;
  logic [NUM_EXP-1:0] mask_q, mask_d;
  logic [TW-1:0]      cnt_q, cnt_d, to_q, to_d;
  logic [1:0]         code_q, code_d, mode_q, mode_d;

  logic [NUM_EXP-1:0] addr_hit, full_hit, active, ptr_oh, upd_mask;
  logic               snoop, sel_full, sel_addr, mism, complete_now, complete_reg, timeout_hit;

  // Table is writable whenever a check is not in flight.
  for (genvar i = 0; i < NUM_EXP; i++) begin : g_ent
    regchk_entry_match #(.XLEN(XLEN), .AW(AW)) u_ent (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .we       (cfg_we && (state_q != RUN) && (cfg_idx == IW'(i))),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .addr_hit (addr_hit[i]),
      .full_hit (full_hit[i])
    );
  end

  always_comb begin
    snoop    = rf_we && (rf_waddr != '0);
    sel_full = 1'b0;
    sel_addr = 1'b0;
    for (int i = 0; i < NUM_EXP; i++) begin
      active[i] = (NW'(i) < n_q);
      ptr_oh[i] = (ptr_q == NW'(i));
      if (ptr_oh[i]) begin
        sel_full = full_hit[i];
        sel_addr = addr_hit[i];
      end
    end

    upd_mask = mask_q;
    ptr_d    = ptr_q;
    mism     = 1'b0;
    if (snoop) begin
      if (mode_q[MODE_UNORDERED]) begin
        upd_mask = mask_q | (full_hit & active);
      end else if (ptr_q < n_q) begin
        if (sel_full) begin
          upd_mask = mask_q | ptr_oh;
          ptr_d    = ptr_q + NW'(1);
        end else if (mode_q[MODE_STRICT] && sel_addr) begin
          mism = 1'b1;
        end
      end
    end
    complete_now = ((upd_mask & active) == active);
    complete_reg = ((mask_q & active) == active);
    timeout_hit  = (to_q != '0) && (cnt_q == to_q - TW'(1));

    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    n_d     = n_q;
    mode_d  = mode_q;
    to_d    = to_q;

    case (state_q)
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + TW'(1);
        // Completion is recognised one edge after the final match lands in the mask.
        if (complete_reg) begin
          state_d = PASS;
          ptr_d   = ptr_q;
        end else begin
          mask_d = upd_mask;
          if (complete_now) begin
            state_d = RUN;
          end else if (abort) begin
            state_d = FAIL;
            code_d  = FAIL_ABORT;
          end else if (mism) begin
            state_d = FAIL;
            code_d  = FAIL_MISMATCH;
          end else if (timeout_hit) begin
            state_d = FAIL;
            code_d  = FAIL_TIMEOUT;
          end
        end
      end
      default: begin
        ptr_d = ptr_q;
        if (start) begin
          mask_d  = '0;
          cnt_d   = '0;
          ptr_d   = '0;
          code_d  = FAIL_NONE;
          n_d     = (num_exp > NW'(NUM_EXP)) ? NW'(NUM_EXP) : num_exp;
          mode_d  = mode;
          to_d    = timeout_cycles;
          state_d = (num_exp == '0) ? PASS : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      code_q  <= FAIL_NONE;
      n_q     <= '0;
      mode_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      to_q    <= to_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == PASS) || (state_q == FAIL);
  assign pass        = (state_q == PASS);
  assign fail_code   = code_q;
  assign match_mask  = mask_q;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_regfile_write_checker.sv
// Directed bench for regfile_write_checker with hand-computed expectations.
module tb_regfile_write_checker;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [3:0]  num_exp = '0;
  logic [1:0]  mode = '0;
  logic [23:0] timeout_cycles = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [7:0]  match_mask;
  logic [23:0] cycle_count;

  int total = 0;
  int passed = 0;

  regfile_write_checker dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .num_exp(num_exp), .mode(mode), .timeout_cycles(timeout_cycles),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .match_mask(match_mask), .cycle_count(cycle_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic cfg(input int idx, input int a, input int d);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_addr = 5'(a); cfg_data = 32'(d);
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic go(input int n, input int m, input int to);
    num_exp = 4'(n); mode = 2'(m); timeout_cycles = 24'(to); start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    rf_we = 1'b1; rf_waddr = 5'(a); rf_wdata = 32'(d);
    tick(1);
    rf_we = 1'b0;
  endtask

  int ta[6] = '{3, 4, 5, 6, 7, 8};
  int td[6] = '{3, 3, 6, 6, 3, 5};

  initial begin
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_mask", match_mask, 0);
    chk("rst_cnt", cycle_count, 0);
    wb_rst_i = 1'b0;
    tick(1);

    // Ordered pass with idle gaps
    for (int i = 0; i < 6; i++) cfg(i, ta[i], td[i]);
    go(6, 0, 1000);
    chk("ord_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      wr(ta[i], td[i]);
      if (i < 5) tick(1);
    end
    chk("ord_latency_pass", pass, 0);
    chk("ord_latency_mask", match_mask, 8'h3F);
    tick(1);
    chk("ord_pass", pass, 1);
    chk("ord_done", done, 1);
    chk("ord_code", fail_code, 0);
    chk("ord_mask", match_mask, 8'h3F);
    chk("ord_cnt", cycle_count, 12);
    tick(3);
    chk("ord_cnt_frozen", cycle_count, 12);

    // Ordered, out of order
    go(6, 0, 1000);
    wr(4, 3);
    chk("ooo_early_x4", match_mask, 8'h00);
    wr(3, 3);
    wr(4, 3);
    chk("ooo_two", match_mask, 8'h03);
    for (int i = 2; i < 6; i++) wr(ta[i], td[i]);
    tick(1);
    chk("ooo_pass", pass, 1);

    // Timeout with the repeat x4 withheld
    go(6, 0, 20);
    wr(4, 3);
    wr(3, 3);
    tick(17);
    chk("to_still_busy", busy, 1);
    tick(1);
    chk("to_done", done, 1);
    chk("to_pass", pass, 0);
    chk("to_code", fail_code, 1);
    chk("to_mask", match_mask, 8'h01);
    chk("to_cnt", cycle_count, 20);

    // Strict mismatch; unrelated register writes are harmless
    go(6, 2, 1000);
    wr(3, 3);
    wr(9, 9);
    chk("strict_unrelated", busy, 1);
    wr(4, 7);
    chk("strict_done", done, 1);
    chk("strict_code", fail_code, 2);
    chk("strict_mask", match_mask, 8'h01);

    // Restart from FAIL, then abort
    go(6, 0, 1000);
    chk("rerun_busy", busy, 1);
    chk("rerun_mask", match_mask, 0);
    chk("rerun_cnt", cycle_count, 0);
    chk("rerun_code", fail_code, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_code", fail_code, 3);
    chk("abort_pass", pass, 0);

    // Unordered with duplicate entries
    cfg(0, 5, 6);
    cfg(1, 5, 6);
    cfg(2, 9, 1);
    go(3, 1, 1000);
    wr(0, 6);
    chk("un_x0_ignored", match_mask, 8'h00);
    wr(9, 1);
    chk("un_x9", match_mask, 8'h04);
    wr(5, 6);
    chk("un_dup", match_mask, 8'h07);
    tick(1);
    chk("un_pass", pass, 1);

    // num_exp == 0 passes immediately
    go(0, 0, 0);
    chk("zero_pass", pass, 1);

    // Abort in the same cycle as the final match
    go(3, 1, 0);
    wr(9, 1);
    abort = 1'b1;
    wr(5, 6);
    abort = 1'b0;
    chk("abort_final_mask", match_mask, 8'h07);
    tick(1);
    chk("abort_final_pass", pass, 1);
    chk("abort_final_code", fail_code, 0);

    // cfg_we during RUN is ignored
    go(3, 1, 0);
    cfg(2, 10, 2);
    wr(9, 1);
    wr(5, 6);
    tick(1);
    chk("cfg_run_pass", pass, 1);

    // Async reset mid-RUN
    go(3, 1, 0);
    wr(9, 1);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_mask", match_mask, 0);
    wb_rst_i = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_write_checker.md
Name: regfile_write_checker

Overview:
- Parametrised hardware checker that snoops the core's register-file write port and compares writes against a programmable table of expected (register, value) pairs.
- Modes: ordered or unordered matching, optional strict mismatch detection, programmable cycle timeout.
- Reports busy/done/pass/fail plus a per-entry match mask, so benches and the management SoC can read a verdict instead of polling register contents.
- Sits in the user project beside core0, tapped onto the regfile write port.

Parameters:
- XLEN, 32, data width of register writes and expected values.
- AW, 5, register address width (2**AW architectural registers).
- NUM_EXP, 8, number of expectation table entries.
- TW, 24, width of timeout and cycle counters.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset.
- rf_we  in  1  regfile write enable (snooped).
- rf_waddr  in  AW  regfile write address.
- rf_wdata  in  XLEN  regfile write data.
- cfg_we  in  1  write one table entry.
- cfg_idx  in  clog2(NUM_EXP)  entry index.
- cfg_addr  in  AW  expected register.
- cfg_data  in  XLEN  expected value.
- num_exp  in  clog2(NUM_EXP)+1  active entries, 0..NUM_EXP; sampled on start.
- mode  in  2  bit0 = unordered, bit1 = strict; sampled on start.
- timeout_cycles  in  TW  cycle budget; sampled on start.
- start  in  1  begin a check.
- abort  in  1  abandon a running check.
- busy  out  1  high in RUN.
- done  out  1  level, high in PASS or FAIL.
- pass  out  1  level, high in PASS.
- fail_code  out  2  0 none, 1 timeout, 2 mismatch, 3 abort.
- match_mask  out  NUM_EXP  entries satisfied so far.
- cycle_count  out  TW  RUN cycles elapsed.

Behaviour:
- Reset: wb_rst_i is asynchronous, active-high.
  - State goes to IDLE.
  - All outputs, match_mask, cycle_count and the ordered pointer go to 0.
  - Table contents are also cleared to 0.
- States: IDLE, RUN, PASS, FAIL.
- cfg_we:
  - Accepted in IDLE, PASS and FAIL; ignored in RUN.
  - cfg_idx >= NUM_EXP is ignored.
- start:
  - From IDLE, PASS or FAIL, start enters RUN on the next edge.
  - On entry it clears match_mask, cycle_count, the pointer and fail_code, and latches num_exp, mode and timeout_cycles.
  - start in RUN is ignored.
  - If the latched num_exp == 0, the block goes directly to PASS instead of RUN.
- Snooping:
  - Writes are observed only in RUN.
  - Writes with rf_waddr == 0 are ignored.
  - Matching is event-based: a register value written before start never satisfies an entry.
- Ordered mode (mode[0]=0):
  - Pointer k starts at 0.
  - A write equal to entry k in both address and data sets match_mask[k] and increments k.
  - At most one entry advances per write, even if entry k+1 is identical.
  - Strict (mode[1]=1): a write to addr[k] with different data goes to FAIL, code 2.
- Unordered mode (mode[0]=1):
  - Any write sets match_mask[i] for every active, unmatched entry i whose addr and data both match; several bits may set in one cycle.
  - Strict has no effect.
- Completion:
  - When all active entries are matched after the update, the block enters PASS on the following edge.
  - Latency: a matching write at edge t gives done = pass = 1 visible after edge t+1.
- Timeout:
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - When cycle_count == timeout_cycles - 1 and completion did not occur this cycle, the block enters FAIL, code 1.
  - timeout_cycles == 0 means no timeout.
- abort:
  - In RUN, abort enters FAIL, code 3.
  - Priority in the same cycle: completion > abort > mismatch > timeout.
- PASS/FAIL:
  - Terminal; outputs hold until the next start or reset.
  - match_mask and cycle_count stay frozen for readback.
- Reset asserted in RUN returns to IDLE immediately with no verdict.

Decomposition:
- Package regchk_pkg holds:
  - state enum (IDLE/RUN/PASS/FAIL);
  - fail code constants (FAIL_NONE, FAIL_TIMEOUT, FAIL_MISMATCH, FAIL_ABORT);
  - mode bit index constants (MODE_UNORDERED, MODE_STRICT).
- One sub-module, regchk_entry_match, instantiated NUM_EXP times:
  - holds one table entry;
  - outputs combinational addr_hit and full_hit for the current snooped write.
- The top level owns the FSM, pointer, mask and counters.

Test Plan:
- Ordered pass: table {x3=3, x4=3, x5=6, x6=6, x7=3, x8=5}, num_exp=6, mode=0, timeout=1000; drive the writes in order with idle gaps -> pass=1 one cycle after the x8=5 write, match_mask=0x3F, fail_code=0.
- Ordered, out of order: same table; write x4=3 before x3=3, then x3=3, then x4=3 and the rest -> the first x4 write does not set bit1, final pass=1; with timeout=20 and the repeat x4 write withheld -> FAIL, fail_code=1, match_mask=0x01, cycle_count=20.
- Strict mismatch: mode=2; after x3=3 matches, write x4=7 -> FAIL the next cycle, fail_code=2, match_mask=0x01.
- Unordered with duplicates: mode=1, entries {x5=6, x5=6, x9=1}; write x9=1 then x5=6 -> match_mask=0x07, pass=1; a write to x0 with matching data sets no bits.
- Edge cases:
  - num_exp=0 -> PASS one cycle after start.
  - abort and the final match in the same cycle -> PASS.
  - cfg_we during RUN leaves the table unchanged.
  - Async wb_rst_i pulse mid-RUN -> busy=0, done=0 with no clock edge.
  - start in FAIL clears mask and count and re-runs.
